// File: rtl/regfile_bypass_sb.sv
// Parametrised register file with N combinational read ports, one bypassed write port,
// optional hardwired-zero R0 and a per-register busy scoreboard (set at issue, cleared at writeback).
module regfile_bypass_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic                       i_wr_en,
    input  logic [ADDR_W-1:0]          i_wr_addr,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_iss_en,
    input  logic [ADDR_W-1:0]          i_iss_addr,
    output logic [ADDR_W:0]            o_busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic [DEPTH-1:0]  w_wr_dec;
    logic [DEPTH-1:0]  w_iss_dec;
    logic [DEPTH-1:0]  w_busy_d;
    logic [ADDR_W:0]   w_busy_cnt_d;

    logic [ADDR_W-1:0] w_rd_addr [NUM_RD];
    logic [NUM_RD-1:0] w_rd_hit;
    logic [NUM_RD-1:0] w_rd_zero;

    // One-hot write/issue decode; R0 is masked out when hardwired to zero.
    always_comb begin
        w_wr_dec  = '0;
        w_iss_dec = '0;
        for (int r = 0; r < DEPTH; r++) begin
            w_wr_dec[r]  = i_wr_en  && (i_wr_addr  == ADDR_W'(r));
            w_iss_dec[r] = i_iss_en && (i_iss_addr == ADDR_W'(r));
        end
        if (ZERO_REG) begin
            w_wr_dec[0]  = 1'b0;
            w_iss_dec[0] = 1'b0;
        end
    end

    // A new producer issuing on the same edge as a writeback keeps the register busy.
    always_comb begin
        w_busy_d = (r_busy & ~w_wr_dec) | w_iss_dec;
    end

    always_comb begin
        w_busy_cnt_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            w_busy_cnt_d = w_busy_cnt_d + (ADDR_W + 1)'(w_busy_d[r]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (w_wr_dec[r]) begin
                    r_mem[r] <= i_wr_data;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_d;
            r_busy_cnt <= w_busy_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign w_rd_addr[g] = i_rd_addr[g*ADDR_W +: ADDR_W];
        assign w_rd_zero[g] = ZERO_REG && (w_rd_addr[g] == '0);
        assign w_rd_hit[g]  = i_wr_en && (i_wr_addr == w_rd_addr[g]);

        assign o_rd_data[g*DATA_W +: DATA_W] = w_rd_zero[g] ? '0 :
                                               w_rd_hit[g]  ? i_wr_data :
                                                              r_mem[w_rd_addr[g]];
        // A result landing this cycle is no longer pending for the reader.
        assign o_rd_busy[g] = !w_rd_zero[g] && r_busy[w_rd_addr[g]] && !w_rd_hit[g];
    end

    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default 16x16 ZERO_REG instance plus a 32x32, 4-port,
// ZERO_REG=0 instance, checked with immediate assertions against hand-computed values.
module tb_regfile_bypass_sb;

    logic clk;
    logic rst_n;

    // Instance A: DATA_W=16, ADDR_W=4, NUM_RD=2, ZERO_REG=1
    logic [7:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [3:0]  a_wr_addr;
    logic [15:0] a_wr_data;
    logic        a_iss_en;
    logic [3:0]  a_iss_addr;
    logic [4:0]  a_busy_cnt;

    // Instance B: DATA_W=32, ADDR_W=5, NUM_RD=4, ZERO_REG=0
    logic [19:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr_en;
    logic [4:0]   b_wr_addr;
    logic [31:0]  b_wr_data;
    logic         b_iss_en;
    logic [4:0]   b_iss_addr;
    logic [5:0]   b_busy_cnt;

    int errors = 0;
    int checks = 0;

    regfile_bypass_sb u_dut_a (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd_addr  (a_rd_addr),
        .o_rd_data  (a_rd_data),
        .o_rd_busy  (a_rd_busy),
        .i_wr_en    (a_wr_en),
        .i_wr_addr  (a_wr_addr),
        .i_wr_data  (a_wr_data),
        .i_iss_en   (a_iss_en),
        .i_iss_addr (a_iss_addr),
        .o_busy_cnt (a_busy_cnt)
    );

    regfile_bypass_sb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (4),
        .ZERO_REG (1'b0)
    ) u_dut_b (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd_addr  (b_rd_addr),
        .o_rd_data  (b_rd_data),
        .o_rd_busy  (b_rd_busy),
        .i_wr_en    (b_wr_en),
        .i_wr_addr  (b_wr_addr),
        .i_wr_data  (b_wr_data),
        .i_iss_en   (b_iss_en),
        .i_iss_addr (b_iss_addr),
        .o_busy_cnt (b_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled between edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_wr_en  = 1'b0;
        a_iss_en = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        a_rd_addr  = '0;
        a_wr_en    = 1'b0;
        a_wr_addr  = '0;
        a_wr_data  = '0;
        a_iss_en   = 1'b0;
        a_iss_addr = '0;
        b_rd_addr  = '0;
        b_wr_en    = 1'b0;
        b_wr_addr  = '0;
        b_wr_data  = '0;
        b_iss_en   = 1'b0;
        b_iss_addr = '0;
        #2;
        chk("reset_rd_data", 64'(a_rd_data), 64'h0);
        chk("reset_busy_cnt", 64'(a_busy_cnt), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Write R7, bypass visible the same cycle on port 0
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 16'hFACE;
        a_rd_addr = {4'd0, 4'd7};
        #1;
        chk("bypass_r7", 64'(a_rd_data[15:0]), 64'hFACE);
        tick();

        // R7 from storage on port 0, R10 bypass on port 1
        a_wr_addr = 4'd10; a_wr_data = 16'hF0CE;
        a_rd_addr = {4'd10, 4'd7};
        #1;
        chk("stored_r7", 64'(a_rd_data[15:0]), 64'hFACE);
        chk("bypass_r10", 64'(a_rd_data[31:16]), 64'hF0CE);
        tick();

        // Write 0xFFFF to hardwired R0
        a_wr_addr = 4'd0; a_wr_data = 16'hFFFF;
        a_rd_addr = {4'd10, 4'd0};
        #1;
        chk("r0_write_cycle", 64'(a_rd_data[15:0]), 64'h0);
        chk("stored_r10", 64'(a_rd_data[31:16]), 64'hF0CE);
        tick();
        a_idle();
        #1;
        chk("r0_after_write", 64'(a_rd_data[15:0]), 64'h0);

        // Issue R3
        a_iss_en = 1'b1; a_iss_addr = 4'd3;
        a_rd_addr = {4'd0, 4'd3};
        #1;
        chk("iss_r3_not_yet_busy", 64'(a_rd_busy[0]), 64'h0);
        tick();
        a_idle();
        #1;
        chk("r3_busy", 64'(a_rd_busy[0]), 64'h1);
        chk("cnt_after_iss_r3", 64'(a_busy_cnt), 64'h1);

        // Writeback R3: busy masked in the write cycle
        a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 16'h1234;
        #1;
        chk("r3_busy_masked", 64'(a_rd_busy[0]), 64'h0);
        chk("r3_bypass", 64'(a_rd_data[15:0]), 64'h1234);
        chk("cnt_before_edge", 64'(a_busy_cnt), 64'h1);
        tick();
        a_idle();
        #1;
        chk("cnt_after_wb_r3", 64'(a_busy_cnt), 64'h0);
        chk("r3_busy_cleared", 64'(a_rd_busy[0]), 64'h0);
        chk("r3_stored", 64'(a_rd_data[15:0]), 64'h1234);

        // Issue and write R5 on the same edge
        a_iss_en = 1'b1; a_iss_addr = 4'd5;
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 16'hBEEF;
        a_rd_addr = {4'd0, 4'd5};
        tick();
        a_idle();
        #1;
        chk("r5_data", 64'(a_rd_data[15:0]), 64'hBEEF);
        chk("r5_still_busy", 64'(a_rd_busy[0]), 64'h1);
        chk("cnt_iss_wr_r5", 64'(a_busy_cnt), 64'h1);

        // Re-issue R5
        a_iss_en = 1'b1; a_iss_addr = 4'd5;
        tick();
        a_idle();
        #1;
        chk("cnt_reissue_r5", 64'(a_busy_cnt), 64'h1);

        // Issue to R0 is ignored
        a_iss_en = 1'b1; a_iss_addr = 4'd0;
        a_rd_addr = {4'd5, 4'd0};
        tick();
        a_idle();
        #1;
        chk("cnt_iss_r0", 64'(a_busy_cnt), 64'h1);
        chk("r0_never_busy", 64'(a_rd_busy[0]), 64'h0);
        chk("r5_busy_port1", 64'(a_rd_busy[1]), 64'h1);

        // Issue R9 while writing back R5
        a_iss_en = 1'b1; a_iss_addr = 4'd9;
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 16'h5555;
        #1;
        chk("r5_masked_port1", 64'(a_rd_busy[1]), 64'h0);
        tick();
        a_idle();
        a_rd_addr = {4'd5, 4'd9};
        #1;
        chk("cnt_r9_in_r5_out", 64'(a_busy_cnt), 64'h1);
        chk("r9_busy", 64'(a_rd_busy[0]), 64'h1);
        chk("r5_free", 64'(a_rd_busy[1]), 64'h0);

        // Asynchronous reset mid-run with a write pending
        a_wr_en = 1'b1; a_wr_addr = 4'd2; a_wr_data = 16'hAAAA;
        a_rd_addr = {4'd2, 4'd7};
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_r7_zero", 64'(a_rd_data[15:0]), 64'h0);
        chk("rst_bypass_r2", 64'(a_rd_data[31:16]), 64'hAAAA);
        chk("rst_cnt", 64'(a_busy_cnt), 64'h0);
        a_rd_addr = {4'd5, 4'd9};
        #1;
        chk("rst_r9_not_busy", 64'(a_rd_busy[0]), 64'h0);
        chk("rst_r5_zero", 64'(a_rd_data[31:16]), 64'h0);
        tick();
        a_idle();
        rst_n = 1'b1;
        a_rd_addr = {4'd2, 4'd10};
        #1;
        chk("rst_r2_discarded", 64'(a_rd_data[31:16]), 64'h0);
        chk("rst_r10_zero", 64'(a_rd_data[15:0]), 64'h0);

        // Wide instance: write every register including R0
        for (int i = 0; i < 32; i++) begin
            b_wr_en = 1'b1; b_wr_addr = 5'(i); b_wr_data = 32'hA500_0000 | 32'(i);
            tick();
        end
        b_wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            for (int p = 0; p < 4; p++) begin
                b_rd_addr[p*5 +: 5] = 5'((i + p * 8) % 32);
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("b_read_p%0d_r%0d", p, (i + p * 8) % 32),
                    64'(b_rd_data[p*32 +: 32]), 64'(32'hA500_0000 | 32'((i + p * 8) % 32)));
            end
        end
        b_rd_addr = '0;
        #1;
        chk("b_r0_writable", 64'(b_rd_data[31:0]), 64'hA500_0000);

        // Issue all 32 registers
        for (int i = 0; i < 32; i++) begin
            b_iss_en = 1'b1; b_iss_addr = 5'(i);
            tick();
        end
        b_iss_en = 1'b0;
        #1;
        chk("b_cnt_all_busy", 64'(b_busy_cnt), 64'd32);
        chk("b_r0_busy", 64'(b_rd_busy), 64'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
